pipelined_cla_adder: RTL
========================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor of the team's fixed 8-bit carry-look-ahead adder.
- Adds or subtracts two WIDTH-bit operands; one GROUP-bit carry-look-ahead slice per pipeline stage, inter-group carry registered between stages.
- Valid/ready handshake on both sides; accepts one operation per cycle.
- Sits in the execute path as the multi-cycle ALU adder; also reused for address generation.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of GROUP.
- GROUP, 8, bits per look-ahead slice (legal: 4, 8, 16).
- NUM_GROUPS, WIDTH/GROUP, derived local constant = pipeline depth; not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A - B (B inverted, carry-in 1); 0 = A + B (carry-in 0)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB (for subtract: 1 = no borrow)
- out_ovf  out  1  signed overflow (only with ADDER_FLAGS_EN)
- out_zero  out  1  out_sum == 0 (only with ADDER_FLAGS_EN)

Behaviour:
- Reset: clk single clock domain; rst_n asynchronous assert, active-low. All stage valid bits cleared, all data registers 0; out_valid=0, out_sum=0, out_cout=0, flags 0. in_ready=1 from the first edge after release.
- Transfer: input handshake when in_valid & in_ready; output handshake when out_valid & out_ready.
- Stage k (0..NUM_GROUPS-1):
  - Holds valid, sub flag, sum bits [0 .. k*GROUP-1] already produced, remaining A/B bits, and the carry into group k.
  - Stage 0 captures operands; B is XORed with in_sub, carry-in = in_sub.
  - Each advance computes group k via the look-ahead slice using the registered carry, then passes bits and carry-out to stage k+1.
- Latency: accept at edge t -> out_valid at edge t+NUM_GROUPS with no stall (4 cycles at defaults). Throughput 1 per cycle.
- Stall: stage k advances iff stage k+1 empty or stage k+1 advances. Last stage advances iff out_ready. in_ready = !stage0_valid | stage0 advances (combinational through the stall chain, no bubble).
- While out_valid & !out_ready: out_sum, out_cout and flags held stable.
- Full pipeline with out_ready low: in_ready low; no operation dropped or duplicated.
- Operands taken modulo 2^WIDTH. out_cout is the true carry out of bit WIDTH-1, including the subtract carry-in.
- Results leave in acceptance order.
- Reset mid-operation: all in-flight operations discarded; no result emitted for them.
- in_a/in_b/in_sub are don't-care when in_valid=0; no register changes on a non-accepted cycle.

Optional Feature:
- Macro ADDER_FLAGS_EN.
- Defined: out_ovf and out_zero ports exist and are registered alongside out_sum.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero computed per group as the sum forms (AND-accumulated through stages), not as a final wide reduce.
- Undefined: both ports and their registers absent; all other behaviour identical.

Decomposition:
- Shared include/package:
  - legal-GROUP check macro
  - ADD/SUB opcode constant (in_sub encoding)
  - NUM_GROUPS derivation function
- One natural sub-module, cla_group_adder: combinational GROUP-bit look-ahead slice.
  - Inputs: a, b, cin. Outputs: sum, cout, group P, group G.
  - Instantiated once per stage via generate.

Test Plan (WIDTH=32, GROUP=8):
1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_sum=0. Release -> in_ready=1 next edge, no spurious output.
2. 0xFFFFFFFF + 0x00000001, sub=0 -> exactly 4 cycles later out_sum=0x00000000, out_cout=1 (carry ripples through all stages).
3. Subtract: 5 - 7 -> out_sum=0xFFFFFFFE, out_cout=0. Then 7 - 5 -> 0x00000002, out_cout=1.
4. Stream 8 back-to-back random ops with out_ready=1 -> 8 results on consecutive cycles, in order, matching a reference model.
5. Backpressure: fill pipeline, drop out_ready for 3 cycles -> in_ready=0, out_sum stable. Restore -> all results delivered in order, none lost; assert rst_n mid-stream -> in-flight ops vanish.
6. Flags (ADDER_FLAGS_EN): 0x7FFFFFFF + 1 -> out_ovf=1, out_zero=0; 1 - 1 -> out_zero=1, out_ovf=0. Without macro, the design compiles cleanly with ports absent.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants for the pipelined carry-look-ahead adder: the legal slice-width
// check, the add/subtract opcode encoding and the pipeline-depth derivation.
`ifndef PIPELINED_CLA_ADDER_PKG_SV
`define PIPELINED_CLA_ADDER_PKG_SV

`define CLA_GROUP_LEGAL(g) (((g) == 4) || ((g) == 8) || ((g) == 16))

package pipelined_cla_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

`endif

// File: rtl/cla_group_adder.sv
// Combinational GROUP-bit carry-look-ahead slice with group propagate/generate outputs.
module cla_group_adder #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] carry;

  assign prop = a ^ b;
  assign gen  = a & b;

  // NOTE: combinational logic uses blocking assignments, and every output gets a
  // default first so no path through the loop can leave a latch behind.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    p        = 1'b1;
    g        = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      if (i > 0) carry[i] = gen[i-1] | (prop[i-1] & carry[i-1]);
      g = gen[i] | (prop[i] & g);
      p = p & prop[i];
    end
  end

  assign sum  = prop ^ carry;
  assign cout = g | (p & cin);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one look-ahead slice per stage, carry registered between
// stages, valid/ready on both sides. Define ADDER_FLAGS_EN for out_ovf/out_zero.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int NUM_GROUPS = calc_num_groups(WIDTH, GROUP);

  if (!`CLA_GROUP_LEGAL(GROUP) || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: illegal GROUP/WIDTH combination");
  end

  logic [NUM_GROUPS-1:0] st_valid;
  logic [NUM_GROUPS-1:0] adv;
  logic [NUM_GROUPS-1:0] st_carry;
  logic [WIDTH-1:0]      st_a    [NUM_GROUPS];
  logic [WIDTH-1:0]      st_b    [NUM_GROUPS];
  logic [WIDTH-1:0]      st_sum  [NUM_GROUPS];
  logic [WIDTH-1:0]      nxt_sum [NUM_GROUPS];
  logic [GROUP-1:0]      grp_sum [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] grp_cout;
  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS-1:0] grp_g;
  logic                  accept;
  logic                  drain;
`ifdef ADDER_FLAGS_EN
  logic [NUM_GROUPS-1:0] st_zero;
  logic                  msb_cin;
`endif

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
    cla_group_adder #(.GROUP(GROUP)) u_slice (
      .a    (st_a[k][k*GROUP +: GROUP]),
      .b    (st_b[k][k*GROUP +: GROUP]),
      .cin  (st_carry[k]),
      .sum  (grp_sum[k]),
      .cout (grp_cout[k]),
      .p    (grp_p[k]),
      .g    (grp_g[k])
    );
  end

  // Advance decisions ripple back from the output register so a draining pipe
  // accepts a new operation in the same cycle without a bubble.
  assign drain = !out_valid || out_ready;

  always_comb begin
    adv = '0;
    adv[NUM_GROUPS-1] = st_valid[NUM_GROUPS-1] & drain;
    for (int k = NUM_GROUPS - 2; k >= 0; k--) begin
      adv[k] = st_valid[k] & (!st_valid[k+1] | adv[k+1]);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_GROUPS; k++) begin
      nxt_sum[k] = st_sum[k];
      nxt_sum[k][k*GROUP +: GROUP] = grp_sum[k];
    end
  end

  assign in_ready = !st_valid[0] || adv[0];
  assign accept   = in_valid && in_ready;

`ifdef ADDER_FLAGS_EN
  assign msb_cin = st_a[NUM_GROUPS-1][WIDTH-1] ^ st_b[NUM_GROUPS-1][WIDTH-1]
                 ^ grp_sum[NUM_GROUPS-1][GROUP-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-stage data arrays are cleared too, not just the valid bits,
      // so every register reads zero straight out of reset.
      st_valid  <= '0;
      st_carry  <= '0;
      for (int k = 0; k < NUM_GROUPS; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef ADDER_FLAGS_EN
      st_zero   <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
`endif
    end else begin
      st_valid[0] <= accept | (st_valid[0] & ~adv[0]);
      if (accept) begin
        st_a[0]     <= in_a;
        st_b[0]     <= in_b ^ {WIDTH{in_sub == OP_SUB}};
        st_carry[0] <= (in_sub == OP_SUB);
        st_sum[0]   <= '0;
`ifdef ADDER_FLAGS_EN
        st_zero[0]  <= 1'b1;
`endif
      end

      for (int k = 1; k < NUM_GROUPS; k++) begin
        st_valid[k] <= adv[k-1] | (st_valid[k] & ~adv[k]);
        if (adv[k-1]) begin
          st_a[k]     <= st_a[k-1];
          st_b[k]     <= st_b[k-1];
          st_sum[k]   <= nxt_sum[k-1];
          st_carry[k] <= grp_cout[k-1];
`ifdef ADDER_FLAGS_EN
          st_zero[k]  <= st_zero[k-1] & (grp_sum[k-1] == '0);
`endif
        end
      end

      out_valid <= adv[NUM_GROUPS-1] | (out_valid & ~out_ready);
      if (adv[NUM_GROUPS-1]) begin
        out_sum  <= nxt_sum[NUM_GROUPS-1];
        out_cout <= grp_cout[NUM_GROUPS-1];
`ifdef ADDER_FLAGS_EN
        out_ovf  <= msb_cin ^ grp_cout[NUM_GROUPS-1];
        out_zero <= st_zero[NUM_GROUPS-1] & (grp_sum[NUM_GROUPS-1] == '0);
`endif
      end
    end
  end

endmodule
